// File: rtl/map_arb_pkg.sv
// Shared constants, tag bit positions and CPU probe FSM encoding for the map port arbiter.
package map_arb_pkg;

  localparam int TAG_W    = 4;
  localparam int TAG_VID  = 3;
  localparam int TAG_CPU  = 2;
  localparam int TAG_OOB  = 1;
  localparam int TAG_DROP = 0;

  localparam int MAP_DIM   = 128;
  localparam int CELL_W    = $clog2(MAP_DIM);
  localparam int PIX_SHIFT = 2;
  localparam logic [9:0] OOB_LIMIT = 10'd512;

  typedef enum logic [1:0] {
    C_IDLE = 2'b00,
    C_PEND = 2'b01,
    C_INFL = 2'b10,
    C_REL  = 2'b11
  } cpu_state_e;

  function automatic logic is_oob(input logic [9:0] row, input logic [9:0] col);
    return (row >= OOB_LIMIT) || (col >= OOB_LIMIT);
  endfunction

  function automatic logic [CELL_W-1:0] pix_to_cell(input logic [9:0] pix);
    return pix[PIX_SHIFT +: CELL_W];
  endfunction

endpackage

// File: rtl/map_port_arbiter_if.sv
// Bus bundle for the map port arbiter: video requester, CPU probe and world-map read port.
interface map_port_arbiter_if;

  logic       vid_req;
  logic [9:0] vid_row;
  logic [9:0] vid_col;
  logic [1:0] vid_pixel;
  logic       vid_valid;
  logic       cpu_req;
  logic [6:0] cpu_x;
  logic [6:0] cpu_y;
  logic       cpu_ack;
  logic [1:0] cpu_data;
  logic       map_rd;
  logic [6:0] map_row;
  logic [6:0] map_col;
  logic [1:0] map_data;
  logic [7:0] starve_cnt;

  modport master (
    output vid_req, vid_row, vid_col, cpu_req, cpu_x, cpu_y, map_data,
    input  vid_pixel, vid_valid, cpu_ack, cpu_data, map_rd, map_row, map_col, starve_cnt
  );

  modport slave (
    input  vid_req, vid_row, vid_col, cpu_req, cpu_x, cpu_y, map_data,
    output vid_pixel, vid_valid, cpu_ack, cpu_data, map_rd, map_row, map_col, starve_cnt
  );

endinterface

// File: rtl/map_tag_pipe.sv
// Fixed-depth shift register of {valid, tag} that lines slot tags up with the map read data.
module map_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tag_in,
  output logic [WIDTH-1:0] tag_out,
  output logic             valid_out
);

  logic [DEPTH-1:0][WIDTH:0] stage_r;

  // advance every slot tag one stage per cycle; empty slots travel as all-zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_r <= '0;
    end else begin
      stage_r[0] <= {|tag_in, tag_in};
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign tag_out   = stage_r[DEPTH-1][WIDTH-1:0];
  assign valid_out = stage_r[DEPTH-1][WIDTH];

endmodule

// File: rtl/map_port_arbiter.sv
// Shares the world-map read port between the real-time video path and a CPU probe,
// with a starvation guard that lets a long-waiting CPU steal one video slot.
module map_port_arbiter
  import map_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 16,
  parameter int MAP_LAT      = 1
) (
  input logic               clk,
  input logic               reset,
  map_port_arbiter_if.slave bus
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  cpu_state_e        state_r;
  logic [7:0]        wait_r;
  logic [CELL_W-1:0] cpu_x_r;
  logic [CELL_W-1:0] cpu_y_r;
  logic [1:0]        last_pix_r;

  logic              oob_s;
  logic              pend_s;
  logic              vid_hit_s;
  logic              force_s;
  logic              vid_read_s;
  logic              cpu_grant_s;
  logic [TAG_W-1:0]  tag_in_s;
  logic [TAG_W-1:0]  tag_out_s;
  logic              tag_valid_s;

  // slot decision: forced CPU, then video, then CPU, then idle
  always_comb begin
    oob_s       = is_oob(bus.vid_row, bus.vid_col);
    pend_s      = (state_r == C_PEND);
    vid_hit_s   = bus.vid_req & ~oob_s;
    force_s     = vid_hit_s & pend_s & (wait_r == LIMIT);
    vid_read_s  = vid_hit_s & ~force_s;
    cpu_grant_s = pend_s & (force_s | ~vid_hit_s);
    tag_in_s           = '0;
    tag_in_s[TAG_VID]  = vid_read_s;
    tag_in_s[TAG_CPU]  = cpu_grant_s;
    tag_in_s[TAG_OOB]  = bus.vid_req & oob_s;
    tag_in_s[TAG_DROP] = force_s;
  end

  map_tag_pipe #(
    .DEPTH (MAP_LAT + 1),
    .WIDTH (TAG_W)
  ) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .tag_in    (tag_in_s),
    .tag_out   (tag_out_s),
    .valid_out (tag_valid_s)
  );

  // map port is driven in the cycle after the slot decision
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.map_rd  <= 1'b0;
      bus.map_row <= 7'd0;
      bus.map_col <= 7'd0;
    end else begin
      bus.map_rd <= vid_read_s | cpu_grant_s;
      if (vid_read_s) begin
        bus.map_row <= pix_to_cell(bus.vid_row);
        bus.map_col <= pix_to_cell(bus.vid_col);
      end else if (cpu_grant_s) begin
        bus.map_row <= cpu_y_r;
        bus.map_col <= cpu_x_r;
      end else begin
        bus.map_row <= 7'd0;
        bus.map_col <= 7'd0;
      end
    end
  end

  // CPU probe FSM with its wait counter and registered ack/data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= C_IDLE;
      wait_r       <= 8'd0;
      cpu_x_r      <= 7'd0;
      cpu_y_r      <= 7'd0;
      bus.cpu_ack  <= 1'b0;
      bus.cpu_data <= 2'b00;
    end else begin
      bus.cpu_ack <= 1'b0;
      case (state_r)
        C_IDLE: begin
          wait_r <= 8'd0;
          if (bus.cpu_req) begin
            cpu_x_r <= bus.cpu_x;
            cpu_y_r <= bus.cpu_y;
            state_r <= C_PEND;
          end
        end
        C_PEND: begin
          if (cpu_grant_s) begin
            wait_r  <= 8'd0;
            state_r <= C_INFL;
          end else if (wait_r != LIMIT) begin
            wait_r <= wait_r + 8'd1;
          end
        end
        C_INFL: begin
          wait_r <= 8'd0;
          if (tag_valid_s && tag_out_s[TAG_CPU]) begin
            bus.cpu_ack  <= 1'b1;
            bus.cpu_data <= bus.map_data;
            state_r      <= C_REL;
          end
        end
        C_REL: begin
          // a request still held here has already been served
          wait_r <= 8'd0;
          if (!bus.cpu_req) begin
            state_r <= C_IDLE;
          end
        end
        default: begin
          wait_r  <= 8'd0;
          state_r <= C_IDLE;
        end
      endcase
    end
  end

  // video result capture; every video tag pulses vid_valid at the same latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.vid_valid  <= 1'b0;
      bus.vid_pixel  <= 2'b00;
      last_pix_r     <= 2'b00;
      bus.starve_cnt <= 8'd0;
    end else begin
      bus.vid_valid <= 1'b0;
      if (force_s && (bus.starve_cnt != 8'hFF)) begin
        bus.starve_cnt <= bus.starve_cnt + 8'd1;
      end
      if (tag_valid_s) begin
        if (tag_out_s[TAG_VID]) begin
          bus.vid_valid <= 1'b1;
          bus.vid_pixel <= bus.map_data;
          last_pix_r    <= bus.map_data;
        end else if (tag_out_s[TAG_DROP]) begin
          bus.vid_valid <= 1'b1;
          bus.vid_pixel <= last_pix_r;
        end else if (tag_out_s[TAG_OOB]) begin
          bus.vid_valid <= 1'b1;
          bus.vid_pixel <= 2'b00;
        end
      end
    end
  end

endmodule
